// File: rtl/cmd_cfg_multi.sv
// cmd_cfg_multi: command-driven config register file and capture RAM dump engine; define CMD_CFG_MULTI_DUMP_EN to enable opcode 11 interleaved multi-channel dump.
module cmd_cfg_multi #(
  parameter int NUM_CH  = 5,
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic                clk,
  input  logic                clr_cmd_rdy,
  input  logic [15:0]         cmd,
  input  logic                cmd_rdy,
  input  logic                resp_sent,
  input  logic                set_capture_done,
  input  logic [LOG2-1:0]     waddr,
  input  logic [8*NUM_CH-1:0] rdata,
  output logic [LOG2-1:0]     raddr,
  output logic [7:0]          resp,
  output logic                send_resp,
  output logic                cmd_done,
  output logic [5:0]          TrigCfg,
  output logic [5*NUM_CH-1:0] ch_trig_cfg,
  output logic [3:0]          decimator,
  output logic [7:0]          VIH,
  output logic [7:0]          VIL,
  output logic [7:0]          matchH,
  output logic [7:0]          matchL,
  output logic [7:0]          maskH,
  output logic [7:0]          maskL,
  output logic [7:0]          baud_cntH,
  output logic [7:0]          baud_cntL,
  output logic [LOG2-1:0]     trig_pos
);
`ifdef CMD_CFG_MULTI_DUMP_EN
  localparam logic DUMP_EN = 1'b1;
`else
  localparam logic DUMP_EN = 1'b0;
`endif
  localparam int NREG = 20;
  typedef enum logic [2:0] {IDLE, FETCH, SEND, WAIT, DONE} state_t;
  state_t            state_q, state_d;
  logic [LOG2-1:0]   ptr_q, ptr_d, cnt_q, cnt_d;
  logic [NUM_CH-1:0] mask_q, mask_d, dmask;
  logic [2:0]        ch_q, ch_d;
  logic              dump_q, dump_d, addr_ok, accept;
  logic [7:0]        resp_q, resp_d, rd_val, dbyte;
  logic [7:0]        cfg_q [NREG];
  logic [7:0]        cfg_d [NREG];
  logic [1:0]        op;
  logic [5:0]        addr;
  logic [2:0]        dch;
  logic [3:0]        first, nxt, restart;
  // Registers are stored already masked to their width, so reads are plain zero-extension.
  function automatic logic [7:0] wmask(input int a);
    return a == 0 ? 8'h3F : a <= 8 ? 8'h1F : a == 9 ? 8'h0F :
           a == 18 ? 8'((1 << (LOG2 - 8)) - 1) : 8'hFF;
  endfunction
  function automatic logic [7:0] rst_val(input int a);
    return a == 0 ? 8'h03 : a <= 8 ? 8'h01 : a == 10 ? 8'hAA : a == 11 ? 8'h55 :
           a == 16 ? 8'h06 : a == 17 ? 8'hC8 : a == 19 ? 8'h01 : 8'h00;
  endfunction
  // Lowest set channel in m strictly above index s; bit 3 flags that one exists.
  function automatic logic [3:0] next_ch(input logic [NUM_CH-1:0] m, input int s);
    next_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i] && i > s) next_ch = {1'b1, 3'(i)};
  endfunction
  assign op      = cmd[15:14];
  assign addr    = cmd[13:8];
  assign dch     = cmd[10:8];
  assign accept  = state_q == IDLE && cmd_rdy;
  assign addr_ok = int'(addr) < NREG && !(int'(addr) >= 1 && int'(addr) <= 8 && int'(addr) > NUM_CH);
  assign dmask   = op == 2'b10 ? ((dch != 3'd0 && int'(dch) <= NUM_CH) ? NUM_CH'(1) << (dch - 3'd1) : '0)
                               : (DUMP_EN ? cmd[NUM_CH-1:0] : '0);
  assign first   = next_ch(dmask, -1);
  assign nxt     = next_ch(mask_q, int'(ch_q));
  assign restart = next_ch(mask_q, -1);
  assign dbyte   = 8'(rdata >> {ch_q, 3'b000});
  // Register read mux for opcode 00.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NREG; i++)
      if (int'(addr) == i) rd_val = cfg_q[i];
  end
  // Register writes land in the accept cycle; capture-done is ORed in afterwards so it wins.
  always_comb begin
    cfg_d = cfg_q;
    for (int i = 0; i < NREG; i++)
      if (accept && op == 2'b01 && addr_ok && int'(addr) == i) cfg_d[i] = cmd[7:0] & wmask(i);
    cfg_d[0][5] = cfg_d[0][5] | set_capture_done;
  end
  // Command FSM next-state: single-byte replies and multi-byte dumps share FETCH/SEND/WAIT.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    ch_d    = ch_q;
    dump_d  = dump_q;
    resp_d  = resp_q;
    case (state_q)
      IDLE: if (cmd_rdy) begin
        resp_d  = op == 2'b00 && addr_ok ? rd_val : op == 2'b01 && addr_ok ? 8'hA5 : 8'hEE;
        dump_d  = op[1] && first[3];
        mask_d  = dmask;
        ch_d    = first[2:0];
        ptr_d   = op[1] && first[3] ? waddr : ptr_q;
        cnt_d   = '0;
        state_d = op[1] && first[3] ? FETCH : SEND;
      end
      FETCH: state_d = SEND;
      SEND: begin
        resp_d  = dump_q ? dbyte : resp_q;
        state_d = WAIT;
      end
      WAIT: if (resp_sent) begin
        state_d = !dump_q || !restart[3] || (!nxt[3] && cnt_q == LOG2'(ENTRIES - 1)) ? DONE : FETCH;
        ch_d    = nxt[3] ? nxt[2:0] : restart[2:0];
        ptr_d   = nxt[3] ? ptr_q : ptr_q == LOG2'(ENTRIES - 1) ? '0 : ptr_q + 1'b1;
        cnt_d   = nxt[3] ? cnt_q : cnt_q + 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State and config registers; clr_cmd_rdy aborts any dump immediately.
  always_ff @(posedge clk or posedge clr_cmd_rdy) begin
    if (clr_cmd_rdy) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      ch_q    <= '0;
      dump_q  <= 1'b0;
      resp_q  <= '0;
      for (int i = 0; i < NREG; i++) cfg_q[i] <= rst_val(i);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      ch_q    <= ch_d;
      dump_q  <= dump_d;
      resp_q  <= resp_d;
      cfg_q   <= cfg_d;
    end
  end
  assign raddr     = ptr_q;
  assign send_resp = state_q == SEND;
  assign cmd_done  = state_q == DONE;
  assign resp      = state_q == SEND && dump_q ? dbyte : resp_q;
  assign TrigCfg   = cfg_q[0][5:0];
  assign decimator = cfg_q[9][3:0];
  assign VIH       = cfg_q[10];
  assign VIL       = cfg_q[11];
  assign matchH    = cfg_q[12];
  assign matchL    = cfg_q[13];
  assign maskH     = cfg_q[14];
  assign maskL     = cfg_q[15];
  assign baud_cntH = cfg_q[16];
  assign baud_cntL = cfg_q[17];
  assign trig_pos  = {cfg_q[18][LOG2-9:0], cfg_q[19]};
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_trig_cfg[5*c +: 5] = cfg_q[c+1][4:0];
  end
endmodule

// File: tb/tb_cmd_cfg_multi.sv
// tb_cmd_cfg_multi: randomized scoreboard bench for cmd_cfg_multi against a register-map/dump reference model.
module tb_cmd_cfg_multi;
  localparam int NUM_CH = 5;
  localparam int ENTRIES = 384;
  localparam int LOG2 = 9;
  localparam int LIMIT = 20000;
  logic                clk = 1'b0;
  logic                clr_cmd_rdy = 1'b0;
  logic [15:0]         cmd = '0;
  logic                cmd_rdy = 1'b0;
  logic                resp_sent = 1'b0;
  logic                set_capture_done = 1'b0;
  logic [LOG2-1:0]     waddr = '0;
  logic [8*NUM_CH-1:0] rdata = '0;
  logic [LOG2-1:0]     raddr;
  logic [7:0]          resp;
  logic                send_resp, cmd_done;
  logic [5:0]          TrigCfg;
  logic [5*NUM_CH-1:0] ch_trig_cfg;
  logic [3:0]          decimator;
  logic [7:0]          VIH, VIL, matchH, matchL, maskH, maskL, baud_cntH, baud_cntL;
  logic [LOG2-1:0]     trig_pos;
  int npass = 0, ntot = 0, nbytes = 0, rst_gen = 0;
  int mdl [20];
  logic [7:0] mem [NUM_CH][ENTRIES];
  logic [7:0] exp_q [$];
  logic prev_sr = 1'b0;

  cmd_cfg_multi #(.NUM_CH(NUM_CH), .ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk(clk), .clr_cmd_rdy(clr_cmd_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy), .resp_sent(resp_sent),
    .set_capture_done(set_capture_done), .waddr(waddr), .rdata(rdata), .raddr(raddr), .resp(resp),
    .send_resp(send_resp), .cmd_done(cmd_done), .TrigCfg(TrigCfg), .ch_trig_cfg(ch_trig_cfg),
    .decimator(decimator), .VIH(VIH), .VIL(VIL), .matchH(matchH), .matchL(matchL), .maskH(maskH),
    .maskL(maskL), .baud_cntH(baud_cntH), .baud_cntL(baud_cntL), .trig_pos(trig_pos));

  always #5 clk = ~clk;

  always @(posedge clk)
    for (int c = 0; c < NUM_CH; c++)
      rdata[8*c +: 8] <= int'(raddr) < ENTRIES ? mem[c][raddr] : 8'h00;

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int wmask(input int a);
    return a == 0 ? 'h3F : a <= 8 ? 'h1F : a == 9 ? 'h0F : a == 18 ? (1 << (LOG2 - 8)) - 1 : 'hFF;
  endfunction

  function automatic bit vaddr(input int a);
    return a <= 19 && !(a >= 1 && a <= 8 && a > NUM_CH);
  endfunction

  function automatic void mdl_reset();
    for (int i = 0; i < 20; i++) mdl[i] = 0;
    mdl[0] = 'h03;
    for (int i = 1; i <= 8; i++) mdl[i] = 'h01;
    mdl[10] = 'hAA; mdl[11] = 'h55; mdl[16] = 'h06; mdl[17] = 'hC8; mdl[19] = 'h01;
  endfunction

  task automatic push_dump(input logic [7:0] m, input int wa);
    for (int k = 0; k < ENTRIES; k++)
      for (int c = 0; c < NUM_CH; c++)
        if (m[c]) exp_q.push_back(mem[c][(wa + k) % ENTRIES]);
  endtask

  task automatic check_cfg();
    chk("TrigCfg", TrigCfg, mdl[0]);
    for (int c = 0; c < NUM_CH; c++) chk("ch_trig_cfg", ch_trig_cfg[5*c +: 5], mdl[c+1]);
    chk("decimator", decimator, mdl[9]);
    chk("VIH", VIH, mdl[10]);
    chk("VIL", VIL, mdl[11]);
    chk("matchH", matchH, mdl[12]);
    chk("matchL", matchL, mdl[13]);
    chk("maskH", maskH, mdl[14]);
    chk("maskL", maskL, mdl[15]);
    chk("baud_cntH", baud_cntH, mdl[16]);
    chk("baud_cntL", baud_cntL, mdl[17]);
    chk("trig_pos", trig_pos, mdl[18] * 256 + mdl[19]);
  endtask

  task automatic do_reset();
    #2 clr_cmd_rdy = 1'b1;
    rst_gen++;
    #1;
    exp_q.delete();
    mdl_reset();
    chk("rst_send_resp", send_resp, 0);
    chk("rst_cmd_done", cmd_done, 0);
    chk("rst_resp", resp, 0);
    chk("rst_raddr", raddr, 0);
    check_cfg();
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic issue(input logic [15:0] c, input logic scd, input int wa);
    int op, a, ch, cyc, n0, cnt;
    logic [7:0] d, m;
    op = int'(c[15:14]); a = int'(c[13:8]); ch = int'(c[10:8]); d = c[7:0];
    @(negedge clk);
    cmd = c; cmd_rdy = 1'b1; set_capture_done = scd; waddr = LOG2'(wa);
    case (op)
      0: exp_q.push_back(vaddr(a) ? 8'(mdl[a]) : 8'hEE);
      1: if (vaddr(a)) begin
        mdl[a] = int'(d) & wmask(a);
        exp_q.push_back(8'hA5);
      end else exp_q.push_back(8'hEE);
      2: if (ch >= 1 && ch <= NUM_CH) push_dump(8'(1 << (ch - 1)), wa);
         else exp_q.push_back(8'hEE);
      default: begin
        m = d & 8'((1 << NUM_CH) - 1);
`ifdef CMD_CFG_MULTI_DUMP_EN
        if (m != 0) push_dump(m, wa);
        else exp_q.push_back(8'hEE);
`else
        exp_q.push_back(8'hEE);
`endif
      end
    endcase
    if (scd) mdl[0] = mdl[0] | 'h20;
    cnt = exp_q.size();
    n0 = nbytes;
    @(negedge clk);
    cmd_rdy = 1'b0; set_capture_done = 1'b0;
    cyc = 0;
    while (!cmd_done && cyc < LIMIT) begin
      cmd = 16'($urandom);
      cmd_rdy = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    cmd_rdy = 1'b0;
    chk("cmd_done_seen", cmd_done, 1);
    if (!cmd_done) begin
      do_reset();
      return;
    end
    chk("bytes_left", exp_q.size(), 0);
    chk("strobes", nbytes - n0, cnt);
    @(negedge clk);
    chk("cmd_done_pulse", cmd_done, 0);
    check_cfg();
  endtask

  always @(negedge clk) begin
    if (send_resp) begin
      nbytes++;
      chk("send_resp_width", prev_sr, 0);
      if (exp_q.size() == 0) chk("unexpected_byte", resp, -1);
      else chk("resp_byte", resp, exp_q.pop_front());
    end
    prev_sr = send_resp;
  end

  always begin : responder
    int g;
    logic [7:0] v;
    @(negedge clk);
    if (send_resp) begin
      g = rst_gen;
      v = resp;
      repeat (1 + $urandom_range(0, 2)) @(negedge clk);
      resp_sent = 1'b1;
      if (g == rst_gen) chk("resp_hold", resp, v);
      @(negedge clk);
      resp_sent = 1'b0;
    end
  end

  initial begin
    int n0, cyc, bad, r;
    logic [15:0] c;
    for (int ch = 0; ch < NUM_CH; ch++)
      for (int a = 0; a < ENTRIES; a++)
        mem[ch][a] = ch == 0 ? 8'(a) : 8'($urandom);
    do_reset();
    issue(16'h4E55, 1'b0, 0);
    issue(16'h0E00, 1'b0, 0);
    issue(16'h0600, 1'b0, 0);
    issue(16'h8000, 1'b0, 0);
    issue(16'h4000, 1'b1, 0);
    issue(16'h52FF, 1'b0, 0);
    issue(16'h1200, 1'b0, 0);
    issue(16'h4147, 1'b0, 0);
    issue(16'h0100, 1'b0, 0);
    issue(16'h8100, 1'b0, 380);
    issue(16'hC005, 1'b0, $urandom_range(0, ENTRIES - 1));
    issue(16'hC0E0, 1'b0, 0);
    issue(16'h8600, 1'b0, 0);
    @(negedge clk);
    cmd = 16'h8100; cmd_rdy = 1'b1; waddr = LOG2'(17);
    push_dump(8'h01, 17);
    n0 = nbytes;
    @(negedge clk);
    cmd_rdy = 1'b0;
    cyc = 0;
    while (nbytes - n0 < 10 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_bytes", nbytes - n0, 10);
    do_reset();
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (cmd_done) bad = 1;
    end
    chk("abort_no_cmd_done", bad, 0);
    issue(16'h4E33, 1'b0, 0);
    issue(16'h0E00, 1'b0, 0);
    for (int i = 0; i < 70; i++) begin
      r = $urandom_range(0, 15);
      if (r == 0) c = {2'b10, 3'b000, 3'($urandom_range(0, 7)), 8'($urandom)};
      else if (r == 1) c = {2'b11, 6'($urandom), 8'(1 << $urandom_range(0, 7)) | 8'(1 << $urandom_range(0, 7))};
      else c = {1'b0, 1'($urandom), 6'($urandom_range(0, 23)), 8'($urandom)};
      issue(c, $urandom_range(0, 3) == 0, $urandom_range(0, ENTRIES - 1));
    end
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
